fdtd_mem_word_wr: RTL and testbench

- Single-word AXI4 write master for the FDTD user plugin; the write-side counterpart of the plugin's word-read master.
- Accepts a word address, data and byte strobe over a simple req/gnt interface.
- Issues one single-beat INCR write on the AW/W channels and waits for the B response.
- Pulses wr_gnt_o on response, with an error flag derived from BRESP.

---
 rtl/fdtd_mem_word_wr.sv | 205 ++++++++++++++++++++
 tb/tb_fdtd_mem_word_wr.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdtd_mem_word_wr.sv
// fdtd_mem_word_wr
// Single-word AXI4 write master for the FDTD user plugin. It is the
// write-side partner of the plugin's word-read master. A requester presents a
// word address, 32-bit data and byte strobe on a req/gnt handshake. The block
// then issues one single-beat INCR write on AW/W and waits for the B response.
// wr_gnt_o pulses when the response arrives, with wr_err_o taken from BRESP[1].
//
// Ports:
//   ACLK, ARESET       clock, synchronous active-high reset
//   AW*_o / AWREADY_i  write address channel (single beat, size 4 bytes, INCR)
//   W*_o / WREADY_i    write data channel (WLAST always 1)
//   B*_i / BREADY_o    write response channel (BID/BUSER ignored)
//   wr_req_i           request, held with stable payload until wr_gnt_o
//   wr_word_addr_i     word address (byte address = {word_addr, 2'b00})
//   wr_data_i          write data
//   wr_strb_i          byte enables
//   wr_gnt_o           one-cycle completion pulse
//   wr_err_o           error flag, valid with wr_gnt_o
//
// Optional feature: define FDTD_MEM_WR_TIMEOUT_EN to add a B-wait watchdog.
// After TIMEOUT_CYCLES cycles in WS_WAIT_B with no response, the block
// completes with an error. A late B response is then ignored.

module fdtd_mem_word_wr #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_USER_WIDTH = 10,
  parameter int AXI_STRB_WIDTH  = AXI4_DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  output logic [AXI4_ID_WIDTH-1:0]   AWID_o,
  output logic [AXI4_ADDR_WIDTH-1:0] AWADDR_o,
  output logic [7:0]                 AWLEN_o,
  output logic [2:0]                 AWSIZE_o,
  output logic [1:0]                 AWBURST_o,
  output logic                       AWLOCK_o,
  output logic [3:0]                 AWCACHE_o,
  output logic [2:0]                 AWPROT_o,
  output logic [3:0]                 AWREGION_o,
  output logic [AXI4_USER_WIDTH-1:0] AWUSER_o,
  output logic [3:0]                 AWQOS_o,
  output logic                       AWVALID_o,
  input  logic                       AWREADY_i,
  output logic [AXI4_DATA_WIDTH-1:0] WDATA_o,
  output logic [AXI_STRB_WIDTH-1:0]  WSTRB_o,
  output logic                       WLAST_o,
  output logic [AXI4_USER_WIDTH-1:0] WUSER_o,
  output logic                       WVALID_o,
  input  logic                       WREADY_i,
  input  logic [AXI4_ID_WIDTH-1:0]   BID_i,
  input  logic [1:0]                 BRESP_i,
  input  logic                       BVALID_i,
  input  logic [AXI4_USER_WIDTH-1:0] BUSER_i,
  output logic                       BREADY_o,
  input  logic                       wr_req_i,
  input  logic [AXI4_ADDR_WIDTH-3:0] wr_word_addr_i,
  input  logic [AXI4_DATA_WIDTH-1:0] wr_data_i,
  input  logic [AXI_STRB_WIDTH-1:0]  wr_strb_i,
  output logic                       wr_gnt_o,
  output logic                       wr_err_o
);

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_SEND,
    WS_WAIT_B
  } wrState_t;

  wrState_t                   r_state;
  wrState_t                   w_stateNext;
  logic                       r_awPend;
  logic                       r_wPend;
  logic                       w_awPendNext;
  logic                       w_wPendNext;
  logic                       w_capture;
  logic                       w_gnt;
  logic                       w_err;
  logic                       w_bReady;
  logic                       w_timeout;
  logic [AXI4_ADDR_WIDTH-3:0] r_wordAddr;
  logic [AXI4_DATA_WIDTH-1:0] r_data;
  logic [AXI_STRB_WIDTH-1:0]  r_strb;

  // The B channel IDs and user bits carry nothing useful with a single
  // outstanding write. Only BRESP[1] separates success from failure.
  logic w_unused;
  assign w_unused = ^{BID_i, BUSER_i, BRESP_i[0]};

  // Fixed single-beat, 4-byte, INCR burst attributes
  assign AWID_o     = '0;
  assign AWLEN_o    = 8'd0;
  assign AWSIZE_o   = 3'd2;
  assign AWBURST_o  = 2'b01;
  assign AWLOCK_o   = 1'b0;
  assign AWCACHE_o  = 4'd0;
  assign AWPROT_o   = 3'd0;
  assign AWREGION_o = 4'd0;
  assign AWUSER_o   = '0;
  assign AWQOS_o    = 4'd0;
  assign WLAST_o    = 1'b1;
  assign WUSER_o    = '0;

  assign AWADDR_o  = {r_wordAddr, 2'b00};
  assign WDATA_o   = r_data;
  assign WSTRB_o   = r_strb;
  // The pend flags are only ever set while in WS_SEND, so they serve
  // directly as the registered valids.
  assign AWVALID_o = r_awPend;
  assign WVALID_o  = r_wPend;
  assign BREADY_o  = w_bReady;
  assign wr_gnt_o  = w_gnt;
  assign wr_err_o  = w_err;

`ifdef FDTD_MEM_WR_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_toCnt;

  // The watchdog is held at zero outside WS_WAIT_B, so it always starts
  // from zero on entry. It counts every cycle that passes without a response.
  always_ff @(posedge ACLK) begin
    if (ARESET || (r_state != WS_WAIT_B)) begin
      r_toCnt <= '0;
    end else if (!BVALID_i) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  assign w_timeout = (r_toCnt == TO_LAST);
`else
  localparam int unused_timeoutCycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // Next-state and handshake decode. AW and W retire independently, and the
  // B wait starts once neither is still pending.
  always_comb begin
    w_stateNext  = r_state;
    w_awPendNext = r_awPend;
    w_wPendNext  = r_wPend;
    w_capture    = 1'b0;
    w_gnt        = 1'b0;
    w_err        = 1'b0;
    w_bReady     = 1'b0;
    case (r_state)
      WS_IDLE: begin
        if (wr_req_i) begin
          w_capture    = 1'b1;
          w_awPendNext = 1'b1;
          w_wPendNext  = 1'b1;
          w_stateNext  = WS_SEND;
        end
      end
      WS_SEND: begin
        w_awPendNext = r_awPend & ~AWREADY_i;
        w_wPendNext  = r_wPend & ~WREADY_i;
        if (!w_awPendNext && !w_wPendNext) begin
          w_stateNext = WS_WAIT_B;
        end
      end
      WS_WAIT_B: begin
        w_bReady = 1'b1;
        if (BVALID_i) begin
          w_gnt       = 1'b1;
          w_err       = BRESP_i[1];
          w_stateNext = WS_IDLE;
        end else if (w_timeout) begin
          w_gnt       = 1'b1;
          w_err       = 1'b1;
          w_stateNext = WS_IDLE;
        end
      end
      default: begin
        w_stateNext = WS_IDLE;
      end
    endcase
  end

  // State, pending flags and the payload captured at request time. The
  // payload stays stable until the next accepted request.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= WS_IDLE;
      r_awPend   <= 1'b0;
      r_wPend    <= 1'b0;
      r_wordAddr <= '0;
      r_data     <= '0;
      r_strb     <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_awPend <= w_awPendNext;
      r_wPend  <= w_wPendNext;
      if (w_capture) begin
        r_wordAddr <= wr_word_addr_i;
        r_data     <= wr_data_i;
        r_strb     <= wr_strb_i;
      end
    end
  end

endmodule

// File: tb/tb_fdtd_mem_word_wr.sv
// tb_fdtd_mem_word_wr
// Self-checking bench for fdtd_mem_word_wr. A scripted AXI slave adds
// per-write delays on AWREADY, WREADY and BVALID. The expected valid,
// ready and grant waveforms are worked out from those delays with plain
// arithmetic, counting cycles from the request cycle (cycle 0).
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// 2 time units after each rising edge.

module tb_fdtd_mem_word_wr;

  localparam int TO_CYC = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] AWID_o;
  logic [31:0] AWADDR_o;
  logic [7:0]  AWLEN_o;
  logic [2:0]  AWSIZE_o;
  logic [1:0]  AWBURST_o;
  logic        AWLOCK_o;
  logic [3:0]  AWCACHE_o;
  logic [2:0]  AWPROT_o;
  logic [3:0]  AWREGION_o;
  logic [9:0]  AWUSER_o;
  logic [3:0]  AWQOS_o;
  logic        AWVALID_o;
  logic        AWREADY_i;
  logic [31:0] WDATA_o;
  logic [3:0]  WSTRB_o;
  logic        WLAST_o;
  logic [9:0]  WUSER_o;
  logic        WVALID_o;
  logic        WREADY_i;
  logic [15:0] BID_i;
  logic [1:0]  BRESP_i;
  logic        BVALID_i;
  logic [9:0]  BUSER_i;
  logic        BREADY_o;
  logic        wr_req_i;
  logic [29:0] wr_word_addr_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_strb_i;
  logic        wr_gnt_o;
  logic        wr_err_o;

  int checks = 0;
  int errors = 0;

  fdtd_mem_word_wr #(
    .AXI4_ADDR_WIDTH(32),
    .AXI4_DATA_WIDTH(32),
    .AXI4_ID_WIDTH  (16),
    .AXI4_USER_WIDTH(10),
    .AXI_STRB_WIDTH (4),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .AWID_o        (AWID_o),
    .AWADDR_o      (AWADDR_o),
    .AWLEN_o       (AWLEN_o),
    .AWSIZE_o      (AWSIZE_o),
    .AWBURST_o     (AWBURST_o),
    .AWLOCK_o      (AWLOCK_o),
    .AWCACHE_o     (AWCACHE_o),
    .AWPROT_o      (AWPROT_o),
    .AWREGION_o    (AWREGION_o),
    .AWUSER_o      (AWUSER_o),
    .AWQOS_o       (AWQOS_o),
    .AWVALID_o     (AWVALID_o),
    .AWREADY_i     (AWREADY_i),
    .WDATA_o       (WDATA_o),
    .WSTRB_o       (WSTRB_o),
    .WLAST_o       (WLAST_o),
    .WUSER_o       (WUSER_o),
    .WVALID_o      (WVALID_o),
    .WREADY_i      (WREADY_i),
    .BID_i         (BID_i),
    .BRESP_i       (BRESP_i),
    .BVALID_i      (BVALID_i),
    .BUSER_i       (BUSER_i),
    .BREADY_o      (BREADY_o),
    .wr_req_i      (wr_req_i),
    .wr_word_addr_i(wr_word_addr_i),
    .wr_data_i     (wr_data_i),
    .wr_strb_i     (wr_strb_i),
    .wr_gnt_o      (wr_gnt_o),
    .wr_err_o      (wr_err_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge ACLK);
    #1;
  endtask

  // Runs one write against the scripted slave, entering and leaving at posedge+1.
  // AW/W handshakes land at cycles 1+aD and 1+wD. WAIT_B starts at
  // 2+max(aD,wD), and BVALID shows up bD cycles later, which is the grant cycle.
  task automatic applyStimulus(input logic [29:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int aD, input int wD,
                               input int bD, input logic [1:0] bresp,
                               input bit keepReq);
    int waitB;
    int gntCyc;
    waitB  = 2 + ((aD > wD) ? aD : wD);
    gntCyc = waitB + bD;
    for (int k = 0; k <= gntCyc; k++) begin
      if (k == 0) begin
        wr_req_i       = 1'b1;
        wr_word_addr_i = addr;
        wr_data_i      = data;
        wr_strb_i      = strb;
      end
      AWREADY_i = (k >= 1 + aD);
      WREADY_i  = (k >= 1 + wD);
      BVALID_i  = (k >= gntCyc);
      BRESP_i   = (k >= gntCyc) ? bresp : ~bresp;
      #1;
      checkOutput("awvalid", AWVALID_o, (k >= 1) && (k <= 1 + aD));
      checkOutput("wvalid", WVALID_o, (k >= 1) && (k <= 1 + wD));
      checkOutput("bready", BREADY_o, k >= waitB);
      checkOutput("gnt", wr_gnt_o, k == gntCyc);
      if ((k >= 1) && (k <= 1 + aD)) checkOutput("awaddr", AWADDR_o, {addr, 2'b00});
      if ((k >= 1) && (k <= 1 + wD)) begin
        checkOutput("wdata", WDATA_o, data);
        checkOutput("wstrb", WSTRB_o, strb);
        checkOutput("wlast", WLAST_o, 1'b1);
      end
      if (k == gntCyc) begin
        checkOutput("err", wr_err_o, bresp[1]);
        if (!keepReq) wr_req_i = 1'b0;
      end
      nextCycle();
    end
    AWREADY_i = 1'b0;
    WREADY_i  = 1'b0;
    BVALID_i  = 1'b0;
    if (!keepReq) begin
      #1;
      checkOutput("idleAwvalid", AWVALID_o, 1'b0);
      checkOutput("idleBready", BREADY_o, 1'b0);
      checkOutput("idleGnt", wr_gnt_o, 1'b0);
      nextCycle();
    end
  endtask

  initial begin
    int gntCount;
    ARESET = 1'b1;
    AWREADY_i = 1'b0;
    WREADY_i = 1'b0;
    BVALID_i = 1'b0;
    BRESP_i = 2'b00;
    BID_i = 16'h1234;
    BUSER_i = 10'h155;
    wr_req_i = 1'b0;
    wr_word_addr_i = '0;
    wr_data_i = '0;
    wr_strb_i = '0;

    // Reset state
    nextCycle();
    nextCycle();
    #1;
    checkOutput("rstAwvalid", AWVALID_o, 1'b0);
    checkOutput("rstWvalid", WVALID_o, 1'b0);
    checkOutput("rstBready", BREADY_o, 1'b0);
    checkOutput("rstGnt", wr_gnt_o, 1'b0);
    checkOutput("rstErr", wr_err_o, 1'b0);
    checkOutput("rstAwaddr", AWADDR_o, 32'h0);
    checkOutput("rstWdata", WDATA_o, 32'h0);
    checkOutput("rstWstrb", WSTRB_o, 4'h0);
    checkOutput("awlen", AWLEN_o, 8'd0);
    checkOutput("awsize", AWSIZE_o, 3'd2);
    checkOutput("awburst", AWBURST_o, 2'b01);
    checkOutput("awid", AWID_o, 16'd0);
    checkOutput("awMisc", {AWLOCK_o, AWCACHE_o, AWPROT_o, AWREGION_o, AWUSER_o, AWQOS_o, WUSER_o}, 64'd0);
    ARESET = 1'b0;
    nextCycle();

    // Directed writes: zero-wait, delayed AW, delayed W, and error responses
    applyStimulus(30'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
    applyStimulus(30'h2A5, 32'h01234567, 4'hF, 3, 0, 0, 2'b00, 1'b0);
    applyStimulus(30'h3F0, 32'hCAFEF00D, 4'h3, 0, 5, 1, 2'b00, 1'b0);
    applyStimulus(30'h011, 32'h11111111, 4'h1, 0, 0, 0, 2'b10, 1'b0);
    applyStimulus(30'h012, 32'h22222222, 4'h2, 1, 1, 2, 2'b11, 1'b0);
    applyStimulus(30'h013, 32'h33333333, 4'h4, 2, 1, 0, 2'b01, 1'b0);

    // A stray BVALID while idle is not accepted
    BVALID_i = 1'b1;
    BRESP_i  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("strayBready", BREADY_o, 1'b0);
      checkOutput("strayGnt", wr_gnt_o, 1'b0);
      nextCycle();
    end
    BVALID_i = 1'b0;

    // Reset asserted while both valids are still pending
    wr_req_i = 1'b1;
    wr_word_addr_i = 30'h0AB;
    wr_data_i = 32'h5A5A5A5A;
    wr_strb_i = 4'hC;
    nextCycle();
    #1;
    checkOutput("sendAwvalid", AWVALID_o, 1'b1);
    checkOutput("sendWvalid", WVALID_o, 1'b1);
    checkOutput("sendBready", BREADY_o, 1'b0);
    ARESET = 1'b1;
    wr_req_i = 1'b0;
    BVALID_i = 1'b1;
    nextCycle();
    #1;
    checkOutput("midRstAwvalid", AWVALID_o, 1'b0);
    checkOutput("midRstWvalid", WVALID_o, 1'b0);
    checkOutput("midRstBready", BREADY_o, 1'b0);
    checkOutput("midRstGnt", wr_gnt_o, 1'b0);
    ARESET = 1'b0;
    BVALID_i = 1'b0;
    nextCycle();
    #1;
    checkOutput("postRstAwvalid", AWVALID_o, 1'b0);
    checkOutput("postRstGnt", wr_gnt_o, 1'b0);
    nextCycle();

    // Randomised writes, some back-to-back with the request held through the grant
    for (int n = 0; n < 25; n++) begin
      applyStimulus(30'($urandom), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), (n != 24) && ($urandom_range(0, 3) == 0));
    end

    // No B response: watchdog grant when enabled, otherwise an indefinite wait
    wr_req_i = 1'b1;
    wr_word_addr_i = 30'h077;
    wr_data_i = 32'h0BADF00D;
    wr_strb_i = 4'hF;
    AWREADY_i = 1'b1;
    WREADY_i = 1'b1;
    gntCount = 0;
`ifdef FDTD_MEM_WR_TIMEOUT_EN
    for (int k = 0; k <= 2 + TO_CYC + 3; k++) begin
      BVALID_i = (k > 2 + TO_CYC - 1);
      #1;
      checkOutput("toGnt", wr_gnt_o, k == 2 + TO_CYC - 1);
      if (k == 2 + TO_CYC - 1) begin
        checkOutput("toErr", wr_err_o, 1'b1);
        wr_req_i = 1'b0;
      end
      if (k > 2 + TO_CYC - 1) checkOutput("lateBready", BREADY_o, 1'b0);
      nextCycle();
    end
    BVALID_i = 1'b0;
`else
    for (int k = 0; k < 1003; k++) begin
      #1;
      if (wr_gnt_o !== 1'b0) gntCount++;
      if (k == 0) wr_req_i = 1'b1;
      nextCycle();
    end
    checkOutput("noTimeoutGnt", gntCount, 0);
    #1;
    checkOutput("stillBready", BREADY_o, 1'b1);
    BVALID_i = 1'b1;
    BRESP_i = 2'b00;
    #1;
    checkOutput("finalGnt", wr_gnt_o, 1'b1);
    checkOutput("finalErr", wr_err_o, 1'b0);
    wr_req_i = 1'b0;
    nextCycle();
    BVALID_i = 1'b0;
    #1;
    checkOutput("finalIdleBready", BREADY_o, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
